req_arbiter8: RTL and testbench

- Shares one downstream resource among 8 requesters. Accepts a request vector and issues one registered grant (one-hot plus 3-bit index).
- Holds the grant until the owner releases it or a hold timeout expires.
- Default build is fixed priority: highest set bit wins, matching the 8-to-3 priority encoding convention (bit 7 → index 7).

---
 rtl/req_arbiter8.sv | 129 ++++++++++++
 tb/tb_req_arbiter8.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter8.sv
// Eight-way request arbiter with a registered one-hot/index grant and a hold timeout.
// Define REQ_ARBITER8_RR_EN for round-robin selection; the default build is fixed priority (highest bit wins).
//
// state | meaning
// IDLE  | no owner; arbitrate on any nonzero req
// BUSY  | grant held until the owner releases or the hold timer expires
// GAP   | one dead cycle between owners
module req_arbiter8 #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [7:0] HOLD_LIM = HOLD_MAX[7:0];
  localparam logic       HOLD_EN  = (HOLD_MAX != 0);

  logic [1:0] state;
  logic [7:0] hold_cnt;
  logic       excl_vld;
  logic [2:0] excl_idx;
  logic [7:0] excl_mask;
  logic [7:0] cand;
  logic [2:0] win;

  // The excluded requester only drops out when someone else is also asking.
  always_comb begin
    excl_mask = 8'd1 << excl_idx;
    cand      = req;
    if (excl_vld && ((req & ~excl_mask) != 8'd0)) begin
      cand = req & ~excl_mask;
    end
  end

`ifdef REQ_ARBITER8_RR_EN
  logic [2:0] ptr;

  // Walk from farthest to nearest so the first candidate after ptr wins.
  always_comb begin
    win = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (cand[ptr + 3'(k + 1)]) begin
        win = ptr + 3'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 3'd7;
    end else if ((state == S_IDLE) && (req != 8'd0)) begin
      ptr <= win;
    end
  end
`else
  always_comb begin
    win = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cand[i]) begin
        win = 3'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gnt      <= 8'd0;
      gnt_idx  <= 3'd0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= 8'd0;
      excl_vld <= 1'b0;
      excl_idx <= 3'd0;
    end else begin
      timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req != 8'd0) begin
            gnt      <= 8'd1 << win;
            gnt_idx  <= win;
            gnt_vld  <= 1'b1;
            hold_cnt <= 8'd1;
            excl_vld <= 1'b0;
            state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Release is checked first so it wins over a coincident timeout.
          if (!req[gnt_idx]) begin
            gnt      <= 8'd0;
            gnt_idx  <= 3'd0;
            gnt_vld  <= 1'b0;
            hold_cnt <= 8'd0;
            state    <= S_GAP;
          end else if (HOLD_EN && (hold_cnt == HOLD_LIM)) begin
            gnt      <= 8'd0;
            gnt_idx  <= 3'd0;
            gnt_vld  <= 1'b0;
            hold_cnt <= 8'd0;
            timeout  <= 1'b1;
            excl_vld <= 1'b1;
            excl_idx <= gnt_idx;
            state    <= S_GAP;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter8.sv
// Directed bench for req_arbiter8: vector table plus multi-cycle timeout, reset and release-race sequences.
module tb_req_arbiter8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req4, req2;
  logic [7:0] gnt4, gnt2;
  logic [2:0] idx4, idx2;
  logic       vld4, vld2;
  logic       to4, to2;

  int checks   = 0;
  int failures = 0;

  req_arbiter8 #(.HOLD_MAX(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req4),
    .gnt(gnt4), .gnt_idx(idx4), .gnt_vld(vld4), .timeout(to4)
  );

  req_arbiter8 #(.HOLD_MAX(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req2),
    .gnt(gnt2), .gnt_idx(idx2), .gnt_vld(vld2), .timeout(to2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle4(input string nm);
    chk({nm, "_vld"}, {7'd0, vld4}, 8'd0);
    chk({nm, "_gnt"}, gnt4, 8'd0);
    chk({nm, "_idx"}, {5'd0, idx4}, 8'd0);
  endtask

  initial begin
`ifdef REQ_ARBITER8_RR_EN
    tbl[0] = '{8'h10, 8'h10, 3'd4};
    tbl[1] = '{8'h81, 8'h80, 3'd7};
    tbl[2] = '{8'h01, 8'h01, 3'd0};
    tbl[3] = '{8'h06, 8'h02, 3'd1};
    tbl[4] = '{8'h7F, 8'h04, 3'd2};
    tbl[5] = '{8'h80, 8'h80, 3'd7};
    tbl[6] = '{8'h30, 8'h10, 3'd4};
    tbl[7] = '{8'h03, 8'h01, 3'd0};
`else
    tbl[0] = '{8'h10, 8'h10, 3'd4};
    tbl[1] = '{8'h81, 8'h80, 3'd7};
    tbl[2] = '{8'h01, 8'h01, 3'd0};
    tbl[3] = '{8'h06, 8'h04, 3'd2};
    tbl[4] = '{8'h7F, 8'h40, 3'd6};
    tbl[5] = '{8'h80, 8'h80, 3'd7};
    tbl[6] = '{8'h30, 8'h20, 3'd5};
    tbl[7] = '{8'h03, 8'h02, 3'd1};
`endif

    // Reset held with all requests active.
    rst_n = 1'b0;
    req4  = 8'hFF;
    req2  = 8'hFF;
    repeat (3) tick();
    chk_idle4("rst_hold");
    chk("rst_hold_to", {7'd0, to4}, 8'd0);
    chk("rst_hold_u2_vld", {7'd0, vld2}, 8'd0);
    req4  = 8'h00;
    req2  = 8'h00;
    rst_n = 1'b1;

    // Vector table: grant, release, gap, idle.
    for (int v = 0; v < 8; v++) begin
      req4 = tbl[v].req;
      tick();
      chk($sformatf("vec%0d_gnt", v), gnt4, tbl[v].gnt);
      chk($sformatf("vec%0d_idx", v), {5'd0, idx4}, {5'd0, tbl[v].idx});
      chk($sformatf("vec%0d_vld", v), {7'd0, vld4}, 8'd1);
      chk($sformatf("vec%0d_to", v), {7'd0, to4}, 8'd0);
      req4 = 8'h00;
      tick();
      chk_idle4($sformatf("vec%0d_gap", v));
      tick();
      chk($sformatf("vec%0d_idle_vld", v), {7'd0, vld4}, 8'd0);
    end

    // A request that pulses between edges in IDLE is not seen.
    #2 req4 = 8'h01;
    #3 req4 = 8'h00;
    tick();
    chk("glitch_vld", {7'd0, vld4}, 8'd0);

    // Reset asserted between edges during a grant clears outputs before the next edge.
    req4 = 8'h20;
    tick();
    chk("midrst_pre_vld", {7'd0, vld4}, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle4("midrst");
    chk("midrst_to", {7'd0, to4}, 8'd0);
    req4 = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_after_to", {7'd0, to4}, 8'd0);

`ifdef REQ_ARBITER8_RR_EN
    // Round robin: each owner releases after one cycle and re-raises.
    req4 = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      tick();
      chk($sformatf("rr%0d_idx", g), {5'd0, idx4}, 8'(g % 8));
      chk($sformatf("rr%0d_vld", g), {7'd0, vld4}, 8'd1);
      req4 = 8'hFF & ~(8'd1 << (g % 8));
      tick();
      chk($sformatf("rr%0d_gap", g), {7'd0, vld4}, 8'd0);
      req4 = 8'hFF;
      tick();
    end
    req4 = 8'h00;
    tick();
    tick();
    tick();
`else
    // Fixed priority: 7 over 0, then 0 after release of 7.
    req4 = 8'h81;
    tick();
    chk("fp_first_idx", {5'd0, idx4}, 8'd7);
    req4 = 8'h01;
    tick();
    chk("fp_gap_vld", {7'd0, vld4}, 8'd0);
    tick();
    chk("fp_idle_vld", {7'd0, vld4}, 8'd0);
    tick();
    chk("fp_second_idx", {5'd0, idx4}, 8'd0);
    chk("fp_second_vld", {7'd0, vld4}, 8'd1);
    req4 = 8'h00;
    tick();
    tick();

    // Timeout with HOLD_MAX=4: 7 held four cycles, pulse, gap, then 1.
    req4 = 8'h82;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("to_hold%0d_idx", c), {5'd0, idx4}, 8'd7);
      chk($sformatf("to_hold%0d_vld", c), {7'd0, vld4}, 8'd1);
      chk($sformatf("to_hold%0d_to", c), {7'd0, to4}, 8'd0);
    end
    tick();
    chk("to_pulse", {7'd0, to4}, 8'd1);
    chk_idle4("to_pulse");
    tick();
    chk("to_pulse_end", {7'd0, to4}, 8'd0);
    chk("to_gap2_vld", {7'd0, vld4}, 8'd0);
    tick();
    chk("to_excl_idx", {5'd0, idx4}, 8'd1);
    chk("to_excl_vld", {7'd0, vld4}, 8'd1);
    req4 = 8'h80;
    tick();
    chk("to_rel1_vld", {7'd0, vld4}, 8'd0);
    tick();
    tick();
    chk("to_back7_idx", {5'd0, idx4}, 8'd7);
    chk("to_back7_vld", {7'd0, vld4}, 8'd1);

    // Sole requester that timed out is granted again.
    repeat (3) tick();
    chk("to_sole_hold_vld", {7'd0, vld4}, 8'd1);
    tick();
    chk("to_sole_pulse", {7'd0, to4}, 8'd1);
    tick();
    tick();
    chk("to_sole_regrant_idx", {5'd0, idx4}, 8'd7);
    chk("to_sole_regrant_vld", {7'd0, vld4}, 8'd1);
    req4 = 8'h00;
    tick();
    tick();
`endif

    // HOLD_MAX=2: release on the same edge the counter reaches 2.
    req2 = 8'h08;
    tick();
    chk("sim_gnt_idx", {5'd0, idx2}, 8'd3);
    chk("sim_gnt_vld", {7'd0, vld2}, 8'd1);
    tick();
    chk("sim_hold_vld", {7'd0, vld2}, 8'd1);
    req2 = 8'h00;
    tick();
    chk("sim_rel_vld", {7'd0, vld2}, 8'd0);
    chk("sim_rel_to", {7'd0, to2}, 8'd0);
    tick();
    chk("sim_gap_to", {7'd0, to2}, 8'd0);
    req2 = 8'h0C;
    tick();
`ifdef REQ_ARBITER8_RR_EN
    chk("sim_noexcl_idx", {5'd0, idx2}, 8'd2);
`else
    chk("sim_noexcl_idx", {5'd0, idx2}, 8'd3);
`endif
    chk("sim_noexcl_vld", {7'd0, vld2}, 8'd1);
    req2 = 8'h00;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
